// File: rtl/rgb_channel_router_if.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_channel_router_if
//  Brief    : Pixel, configuration and status bundle for rgb_channel_router.
//  Revision : 1.0  initial release
// ============================================================================
interface rgb_channel_router_if #(
  parameter int DATA_W = 10
);
  logic              iEnable;
  logic [5:0]        iCfg_sel;
  logic [2:0]        iCfg_inv;
  logic [DATA_W:0]   iCfg_off;
  logic              iCfg_wr;
  logic              iSOF;
  logic              iValid;
  logic [DATA_W-1:0] iRed;
  logic [DATA_W-1:0] iGreen;
  logic [DATA_W-1:0] iBlue;
  logic              oValid;
  logic [DATA_W-1:0] oRed;
  logic [DATA_W-1:0] oGreen;
  logic [DATA_W-1:0] oBlue;
  logic              oCfg_pending;

  modport slave (
    input  iEnable, iCfg_sel, iCfg_inv, iCfg_off, iCfg_wr, iSOF, iValid,
           iRed, iGreen, iBlue,
    output oValid, oRed, oGreen, oBlue, oCfg_pending
  );

  modport master (
    output iEnable, iCfg_sel, iCfg_inv, iCfg_off, iCfg_wr, iSOF, iValid,
           iRed, iGreen, iBlue,
    input  oValid, oRed, oGreen, oBlue, oCfg_pending
  );
endinterface
`default_nettype wire

// File: rtl/rgb_channel_router.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_channel_router
//  Brief    : Two-stage colour-channel router with select, invert and
//             saturating brightness offset; config swaps only at frame start.
//  Revision : 1.0  initial release
// ============================================================================
module rgb_channel_router #(
  parameter int DATA_W = 10
) (
  input  logic                iCLK,
  input  logic                iRST,
  rgb_channel_router_if.slave bus
);
  localparam logic [5:0]        c_selIdentity = 6'b10_01_00;
  localparam logic [DATA_W-1:0] c_maxVal      = {DATA_W{1'b1}};

  logic                     r_enMeta, r_enSync;
  logic [5:0]               r_shSel, r_actSel;
  logic [2:0]               r_shInv, r_actInv;
  logic [DATA_W:0]          r_shOff, r_actOff;
  logic                     r_actEn;
  logic                     r_pending;

  logic [5:0]               w_effSel;
  logic [2:0]               w_effInv;
  logic [DATA_W:0]          w_effOff;
  logic                     w_effEn;

  logic                     r_s1Valid, r_s1En, r_s2Valid;
  logic [2:0]               r_s1Inv;
  logic [DATA_W:0]          r_s1Off;

  logic [2:0][DATA_W-1:0]   w_pix;
  logic [2:0][DATA_W-1:0]   w_out;

  assign w_pix = {bus.iBlue, bus.iGreen, bus.iRed};

  // The SOF pixel already sees the config that active is being loaded with.
  always_comb begin
    w_effSel = r_actSel;
    w_effInv = r_actInv;
    w_effOff = r_actOff;
    w_effEn  = r_actEn;
    if (bus.iSOF) begin
      w_effEn = r_enSync;
      if (bus.iCfg_wr) begin
        w_effSel = bus.iCfg_sel;
        w_effInv = bus.iCfg_inv;
        w_effOff = bus.iCfg_off;
      end else begin
        w_effSel = r_shSel;
        w_effInv = r_shInv;
        w_effOff = r_shOff;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_enMeta  <= 1'b0;
      r_enSync  <= 1'b0;
      r_shSel   <= c_selIdentity;
      r_shInv   <= '0;
      r_shOff   <= '0;
      r_actSel  <= c_selIdentity;
      r_actInv  <= '0;
      r_actOff  <= '0;
      r_actEn   <= 1'b0;
      r_pending <= 1'b0;
      r_s1Valid <= 1'b0;
      r_s1En    <= 1'b0;
      r_s1Inv   <= '0;
      r_s1Off   <= '0;
      r_s2Valid <= 1'b0;
    end else begin
      r_enMeta <= bus.iEnable;
      r_enSync <= r_enMeta;
      if (bus.iCfg_wr) begin
        r_shSel <= bus.iCfg_sel;
        r_shInv <= bus.iCfg_inv;
        r_shOff <= bus.iCfg_off;
      end
      if (bus.iSOF) begin
        r_actSel <= w_effSel;
        r_actInv <= w_effInv;
        r_actOff <= w_effOff;
        r_actEn  <= w_effEn;
      end
      // Frame start clears pending even if a write lands in the same cycle.
      if (bus.iSOF)
        r_pending <= 1'b0;
      else if (bus.iCfg_wr)
        r_pending <= 1'b1;
      r_s1Valid <= bus.iValid;
      if (bus.iValid) begin
        r_s1En  <= w_effEn;
        r_s1Inv <= w_effInv;
        r_s1Off <= w_effOff;
      end
      r_s2Valid <= r_s1Valid;
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_chan
    logic [1:0]               w_sel;
    logic [DATA_W-1:0]        w_src, w_v, w_res;
    logic signed [DATA_W+1:0] w_sum;
    logic [DATA_W-1:0]        r_s1Pix, r_out;

    assign w_sel = w_effSel[2*c +: 2];

    always_comb begin
      w_src = '0;
      case (w_sel)
        2'd0:    w_src = bus.iRed;
        2'd1:    w_src = bus.iGreen;
        2'd2:    w_src = bus.iBlue;
        default: w_src = '0;
      endcase
    end

    assign w_v   = r_s1Inv[c] ? ~r_s1Pix : r_s1Pix;
    assign w_sum = $signed({2'b00, w_v}) + $signed({r_s1Off[DATA_W], r_s1Off});

    always_comb begin
      w_res = w_sum[DATA_W-1:0];
      if (w_sum[DATA_W+1])
        w_res = '0;
      else if (w_sum[DATA_W])
        w_res = c_maxVal;
    end

    // With routing disabled stage 1 holds the raw input, passed through untouched.
    always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
        r_s1Pix <= '0;
        r_out   <= '0;
      end else begin
        if (bus.iValid)
          r_s1Pix <= w_effEn ? w_src : w_pix[c];
        if (r_s1Valid)
          r_out <= r_s1En ? w_res : r_s1Pix;
      end
    end

    assign w_out[c] = r_out;
  end

  assign bus.oValid       = r_s2Valid;
  assign bus.oRed         = w_out[0];
  assign bus.oGreen       = w_out[1];
  assign bus.oBlue        = w_out[2];
  assign bus.oCfg_pending = r_pending;
endmodule
`default_nettype wire
